// File: rtl/approx_err_monitor_if.sv
// Result-pair stream from the exact/approximate adder pair into the error monitor.
// The master is the adder harness; the slave is the monitor.
interface approx_err_monitor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y_exact;
    logic             cout_exact;
    logic [WIDTH-1:0] y_appr;
    logic             cout_appr;

    modport master (
        output in_valid,
        output y_exact,
        output cout_exact,
        output y_appr,
        output cout_appr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  y_exact,
        input  cout_exact,
        input  y_appr,
        input  cout_appr,
        output in_ready
    );
endinterface

// File: rtl/approx_err_monitor.sv
// Error-statistics checker for approximate adders: compares exact vs. approximate
// results and accumulates sample count, error count, sum and max of error distance.
module approx_err_monitor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_samples,
    approx_err_monitor_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [WIDTH:0]       max_ed
);

    localparam int unsigned RW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] accepted;
    logic             ready_q;

    logic             s1_valid;
    logic [RW-1:0]    r_e;
    logic [RW-1:0]    r_a;
    logic             s2_valid;
    logic [RW-1:0]    ed_q;

    logic             fire_c;
    logic             last_c;
    logic [RW-1:0]    ed_c;
    logic [ACC_W:0]   sum_ext_c;

    assign bus.in_ready = ready_q;

    assign fire_c = bus.in_valid && ready_q;
    assign last_c = fire_c && ((accepted + CNT_W'(1)) == target);

    // Absolute difference of the full (carry-extended) results; never wraps.
    always_comb begin
        ed_c = '0;
        if (r_e >= r_a) begin
            ed_c = r_e - r_a;
        end else begin
            ed_c = r_a - r_e;
        end
    end

    // One extra bit catches accumulator overflow for saturation.
    assign sum_ext_c = {1'b0, sum_ed} + (ACC_W + 1)'(ed_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            target     <= '0;
            accepted   <= '0;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            s1_valid   <= 1'b0;
            r_e        <= '0;
            r_a        <= '0;
            s2_valid   <= 1'b0;
            ed_q       <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else begin
            // Stage 1: capture the full results on each handshake.
            s1_valid <= fire_c;
            if (fire_c) begin
                r_e <= {bus.cout_exact, bus.y_exact};
                r_a <= {bus.cout_appr, bus.y_appr};
            end

            // Stage 2: register the error distance.
            s2_valid <= s1_valid;
            if (s1_valid) begin
                ed_q <= ed_c;
            end

            // Accumulate stage.
            if (s2_valid) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                err_cnt    <= err_cnt + CNT_W'(ed_q != '0);
                sum_ed     <= sum_ext_c[ACC_W] ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];
                if (ed_q > max_ed) begin
                    max_ed <= ed_q;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sample_cnt <= '0;
                        err_cnt    <= '0;
                        sum_ed     <= '0;
                        max_ed     <= '0;
                        target     <= n_samples;
                        accepted   <= '0;
                        if (n_samples == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            state   <= RUN;
                            done    <= 1'b0;
                            busy    <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire_c) begin
                        accepted <= accepted + CNT_W'(1);
                    end
                    if (last_c) begin
                        state   <= DRAIN;
                        ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Response-side checker for the approximate-adder evaluation flow: consumes result pairs (exact adder Y/cout vs. approximate adder Y/cout) for the same operands and accumulates error statistics.
- Error statistics: sample count, error count, sum of error distance and maximum error distance.
- Sits downstream of the adder instances (fba/eta2 vs. cra reference) in the evaluation harness.
- Feeds the error-rate (ER) and mean-error-distance (MED) figures used to select adders for the CNN datapath.

Parameters:
- WIDTH, 16, adder result width (Y width; full result is WIDTH+1 bits including cout).
- CNT_W, 32, width of sample/error counters and n_samples.
- ACC_W, 48, width of the error-distance accumulator.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: clear statistics, latch n_samples, begin run.
- n_samples  input  CNT_W  number of result pairs to collect; sampled only on accepted start.
- in_valid  input  1  result pair valid.
- in_ready  output  1  monitor accepts a pair this cycle.
- y_exact  input  WIDTH  exact adder sum.
- cout_exact  input  1  exact adder carry-out.
- y_appr  input  WIDTH  approximate adder sum.
- cout_appr  input  1  approximate adder carry-out.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; statistics final.
- sample_cnt  output  CNT_W  pairs accumulated.
- err_cnt  output  CNT_W  pairs with nonzero error distance.
- sum_ed  output  ACC_W  sum of error distances, saturating.
- max_ed  output  WIDTH+1  largest error distance seen.

Behaviour:
- Reset: state IDLE; in_ready, busy, done = 0; sample_cnt, err_cnt, sum_ed, max_ed = 0; pipeline valids = 0.
  - Reset mid-run aborts immediately; no partial results are retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: clear all statistics, latch n_samples into target, clear accepted count, go to RUN. If n_samples == 0, go directly to DONE (stats 0).
  - RUN: in_ready = 1 while accepted count < target. Handshake fires when in_valid && in_ready; accepted count increments. On the handshake that makes accepted count == target, go to DRAIN; in_ready drops the following cycle.
  - DRAIN: in_ready = 0; wait until the pipeline is empty (2 cycles), then go to DONE.
  - DONE: done = 1; outputs hold until the next start.
  - start in RUN or DRAIN is ignored.
- Datapath: 2-stage pipeline.
  - S1 registers R_e = {cout_exact, y_exact} and R_a = {cout_appr, y_appr} (WIDTH+1 bits, unsigned) on each handshake.
  - S2 computes ED = |R_e - R_a| (WIDTH+1 bits, exact, no wrap) and registers it with a valid bit.
  - Accumulate stage, when S2 valid:
    - sample_cnt += 1.
    - err_cnt += (ED != 0).
    - sum_ed += ED, saturating at 2^ACC_W - 1.
    - max_ed = max(max_ed, ED).
- Latency: a pair accepted at cycle t is reflected in the stat outputs after edge t+3. done asserts the cycle after the last pair is reflected.
- in_valid while in_ready = 0 is not consumed and has no effect. The source holds data until the handshake.
- sample_cnt == target whenever done = 1. err_cnt <= sample_cnt always.

Test Plan:
- Reset, then n_samples = 3, three identical pairs (exact = appr = 0x0000/0, 0xFFFF/0, 0xA9FF/1) -> done; sample_cnt = 3, err_cnt = 0, sum_ed = 0, max_ed = 0.
- n_samples = 2, pairs exact 0x0000/c1 vs appr 0xFFFF/c0 (ED = 1), and exact 0xA9F7/c1 vs appr 0xA9F0/c1 (ED = 7) -> err_cnt = 2, sum_ed = 8, max_ed = 7.
- Backpressure: n_samples = 2, in_valid held high for 5 cycles -> exactly 2 handshakes; in_ready = 0 from the cycle after the 2nd handshake; sample_cnt = 2.
- in_valid gaps (valid 1,0,0,1) with n_samples = 2 -> same stats as back-to-back; done asserts 4 cycles after the last handshake edge.
- n_samples = 0 + start -> done = 1 the next cycle with all stats 0; a second start during RUN of a 4-sample run is ignored (target stays 4).
- rst asserted mid-RUN after 1 handshake -> next cycle all outputs 0, state IDLE; a subsequent start with n_samples = 1 completes normally.
